// File: rtl/mtree_leaf_feeder.sv
// Leaf feeder for the merge sorter tree: demultiplexes one record stream into per-way FIFOs
// and forwards each way to its leaf, closing every RUN_LEN records with an all-ones-key sentinel.
module mtree_leaf_feeder #(
  parameter int W_LOG     = 2,
  parameter int DATW      = 64,
  parameter int KEYW      = 32,
  parameter int DEPTH_LOG = 3,
  parameter int RUN_LOG   = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DATW-1:0]           IN_DATA,
  input  logic [W_LOG-1:0]          IN_WAY,
  input  logic                      IN_VLD,
  output logic                      IN_RDY,
  input  logic [(1<<W_LOG)-1:0]     TREE_FULL,
  output logic [(DATW<<W_LOG)-1:0]  DOUT,
  output logic [(1<<W_LOG)-1:0]     DOUTEN,
  output logic [(1<<W_LOG)-1:0]     RUN_END
);

  localparam int WAYS    = 1 << W_LOG;
  localparam int DEPTH   = 1 << DEPTH_LOG;
  localparam int RUN_LEN = 1 << RUN_LOG;

  localparam logic [DATW-1:0]    SENTINEL = {{(DATW-KEYW){1'b0}}, {KEYW{1'b1}}};
  localparam logic [DEPTH_LOG:0] CNT_FULL = (DEPTH_LOG+1)'(DEPTH);
  localparam logic [RUN_LOG-1:0] RUN_LAST = RUN_LOG'(RUN_LEN - 1);

  typedef enum logic {FILL, TERM} way_state_t;

  logic [WAYS-1:0] full_vec;
  logic            in_fire;

  // Ready depends only on registered occupancy, so a same-cycle pop never frees a full way.
  assign IN_RDY  = ~full_vec[IN_WAY];
  assign in_fire = IN_VLD & IN_RDY;

  genvar gi;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_way
      logic [DATW-1:0]      mem [DEPTH];
      logic [DEPTH_LOG-1:0] wr_ptr_reg;
      logic [DEPTH_LOG-1:0] rd_ptr_reg;
      logic [DEPTH_LOG:0]   count_reg;
      logic [RUN_LOG-1:0]   run_cnt_reg;
      logic [RUN_LOG-1:0]   run_cnt_next;
      way_state_t           state_reg;
      way_state_t           state_next;
      logic                 wr_en;
      logic                 pop;
      logic                 empty;
      logic                 douten;
      logic                 run_end;
      logic [DATW-1:0]      dout;

      assign wr_en         = in_fire && (IN_WAY == W_LOG'(gi));
      assign empty         = (count_reg == '0);
      assign full_vec[gi]  = (count_reg == CNT_FULL);

      always_ff @(posedge CLK) begin
        if (wr_en) begin
          mem[wr_ptr_reg] <= IN_DATA;
        end
      end

      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          wr_ptr_reg  <= '0;
          rd_ptr_reg  <= '0;
          count_reg   <= '0;
          run_cnt_reg <= '0;
          state_reg   <= FILL;
        end else begin
          if (wr_en) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
          end
          if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
          end
          case ({wr_en, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
          endcase
          run_cnt_reg <= run_cnt_next;
          state_reg   <= state_next;
        end
      end

      always_comb begin
        state_next   = state_reg;
        run_cnt_next = run_cnt_reg;
        pop          = 1'b0;
        douten       = 1'b0;
        run_end      = 1'b0;
        dout         = '0;
        if (state_reg == FILL) begin
          if (!empty && !TREE_FULL[gi]) begin
            douten = 1'b1;
            pop    = 1'b1;
            dout   = mem[rd_ptr_reg];
            if (run_cnt_reg == RUN_LAST) begin
              state_next   = TERM;
              run_cnt_next = '0;
            end else begin
              run_cnt_next = run_cnt_reg + 1'b1;
            end
          end
        end else begin
          // The run's last record has left; the sentinel takes the next free leaf slot.
          if (!TREE_FULL[gi]) begin
            douten     = 1'b1;
            run_end    = 1'b1;
            dout       = SENTINEL;
            state_next = FILL;
          end
        end
      end

      assign DOUTEN[gi]               = douten;
      assign RUN_END[gi]              = run_end;
      assign DOUT[DATW*gi +: DATW]    = dout;
    end
  endgenerate

endmodule

// File: tb/tb_mtree_leaf_feeder.sv
// Bench for mtree_leaf_feeder: directed scenarios plus random traffic against a per-way
// queue model where every 16th accepted record on a way is followed by a sentinel.
module tb_mtree_leaf_feeder;

  localparam int W_LOG     = 2;
  localparam int DATW      = 64;
  localparam int KEYW      = 32;
  localparam int DEPTH_LOG = 3;
  localparam int RUN_LOG   = 4;
  localparam int WAYS      = 1 << W_LOG;
  localparam int DEPTH     = 1 << DEPTH_LOG;
  localparam int RUN_LEN   = 1 << RUN_LOG;
  localparam logic [DATW-1:0] SENT = {{(DATW-KEYW){1'b0}}, {KEYW{1'b1}}};

  logic                     CLK;
  logic                     RST;
  logic [DATW-1:0]          IN_DATA;
  logic [W_LOG-1:0]         IN_WAY;
  logic                     IN_VLD;
  logic                     IN_RDY;
  logic [WAYS-1:0]          TREE_FULL;
  logic [DATW*WAYS-1:0]     DOUT;
  logic [WAYS-1:0]          DOUTEN;
  logic [WAYS-1:0]          RUN_END;

  mtree_leaf_feeder #(
    .W_LOG(W_LOG), .DATW(DATW), .KEYW(KEYW), .DEPTH_LOG(DEPTH_LOG), .RUN_LOG(RUN_LOG)
  ) dut (
    .CLK(CLK), .RST(RST), .IN_DATA(IN_DATA), .IN_WAY(IN_WAY), .IN_VLD(IN_VLD),
    .IN_RDY(IN_RDY), .TREE_FULL(TREE_FULL), .DOUT(DOUT), .DOUTEN(DOUTEN), .RUN_END(RUN_END)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Model: expected leaf stream per way; bit DATW flags a sentinel entry.
  logic [DATW:0] q [WAYS][$];
  int occ    [WAYS];
  int acc    [WAYS];
  int en_cnt [WAYS];
  int re_cnt [WAYS];
  int checks = 0;
  int errors = 0;
  logic last_acc;

  function automatic logic [DATW-1:0] rand_rec(input logic [KEYW-1:0] key);
    logic [KEYW-1:0] k;
    k = key;
    if (k == {KEYW{1'b1}}) k = '0;
    return {$urandom(), k};
  endfunction

  task automatic clear_model();
    for (int w = 0; w < WAYS; w++) begin
      q[w].delete();
      occ[w] = 0;
      acc[w] = 0;
    end
  endtask

  task automatic clear_stats();
    for (int w = 0; w < WAYS; w++) begin
      en_cnt[w] = 0;
      re_cnt[w] = 0;
    end
  endtask

  // Called just after a rising edge with inputs set; checks at the falling edge, then advances.
  task automatic check_cycle();
    logic exp_rdy;
    logic en;
    logic re;
    logic [DATW:0] head;
    @(negedge CLK);
    exp_rdy = (occ[IN_WAY] < DEPTH);
    checks++;
    assert (IN_RDY === exp_rdy) else begin
      errors++;
      $error("FAIL in_rdy way=%0d observed=%b expected=%b", IN_WAY, IN_RDY, exp_rdy);
    end
    for (int w = 0; w < WAYS; w++) begin
      en   = !TREE_FULL[w] && (q[w].size() != 0);
      head = en ? q[w][0] : '0;
      re   = head[DATW];
      checks++;
      assert (DOUTEN[w] === en) else begin
        errors++;
        $error("FAIL douten way=%0d observed=%b expected=%b", w, DOUTEN[w], en);
      end
      checks++;
      assert (DOUT[w*DATW +: DATW] === head[DATW-1:0]) else begin
        errors++;
        $error("FAIL dout way=%0d observed=%h expected=%h", w, DOUT[w*DATW +: DATW], head[DATW-1:0]);
      end
      checks++;
      assert (RUN_END[w] === re) else begin
        errors++;
        $error("FAIL run_end way=%0d observed=%b expected=%b", w, RUN_END[w], re);
      end
      if (en) begin
        void'(q[w].pop_front());
        if (!re) occ[w]--;
        en_cnt[w]++;
        if (re) re_cnt[w]++;
      end
    end
    last_acc = IN_VLD && exp_rdy;
    if (last_acc) begin
      q[IN_WAY].push_back({1'b0, IN_DATA});
      occ[IN_WAY]++;
      acc[IN_WAY]++;
      if (acc[IN_WAY] % RUN_LEN == 0) q[IN_WAY].push_back({1'b1, SENT});
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    IN_VLD = 1'b0;
    for (int i = 0; i < n; i++) check_cycle();
  endtask

  task automatic send(input int way, input logic [DATW-1:0] data, output int tries);
    tries = 0;
    IN_VLD  = 1'b1;
    IN_WAY  = W_LOG'(way);
    IN_DATA = data;
    do begin
      check_cycle();
      tries++;
    end while (!last_acc && tries < 200);
    if (!last_acc) begin
      checks++;
      errors++;
      $error("FAIL send_timeout way=%0d observed=%0d expected=<200", way, tries);
    end
    IN_VLD = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    checks++;
    assert (DOUTEN === '0) else begin
      errors++; $error("FAIL %s_douten observed=%b expected=0", tag, DOUTEN);
    end
    checks++;
    assert (RUN_END === '0) else begin
      errors++; $error("FAIL %s_run_end observed=%b expected=0", tag, RUN_END);
    end
    checks++;
    assert (DOUT === '0) else begin
      errors++; $error("FAIL %s_dout observed=%h expected=0", tag, DOUT);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++; $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    IN_VLD = 1'b0;
    #1;
    check_zero_outputs("async_reset");
    clear_model();
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    check_zero_outputs("in_reset");
    RST = 1'b0;
  endtask

  initial begin
    #3ms;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int tries;
    RST = 1'b1; IN_VLD = 1'b0; IN_WAY = '0; IN_DATA = '0; TREE_FULL = '0;
    clear_model();
    clear_stats();
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    check_zero_outputs("reset");
    RST = 1'b0;
    @(negedge CLK);
    checks++;
    assert (IN_RDY === 1'b1) else begin
      errors++; $error("FAIL rdy_after_reset observed=%b expected=1", IN_RDY);
    end
    @(posedge CLK); #1;

    // One full run on way 0 with keys 1..16.
    for (int i = 1; i <= RUN_LEN; i++) send(0, {32'h0, 32'(i)}, tries);
    idle(4);
    check_int("run0_douten_cycles", en_cnt[0], RUN_LEN + 1);
    check_int("run0_run_end", re_cnt[0], 1);

    // Way 0 blocked: 8 accepted, 9th stalls, other ways stay ready.
    TREE_FULL = 4'b0001;
    for (int i = 0; i < DEPTH; i++) send(0, rand_rec(KEYW'(100 + i)), tries);
    IN_VLD = 1'b1; IN_WAY = 2'd0; IN_DATA = rand_rec(KEYW'(200));
    check_cycle();
    check_int("blocked_9th_accepted", int'(last_acc), 0);
    IN_VLD = 1'b0; IN_WAY = 2'd1;
    check_cycle();
    check_int("way1_ready", int'(IN_RDY), 1);
    clear_stats();
    idle(3);
    check_int("blocked_douten", en_cnt[0], 0);

    // Release: first pop frees a slot one cycle later, so the 9th lands on the 2nd try.
    TREE_FULL = '0;
    send(0, rand_rec(KEYW'(200)), tries);
    check_int("release_tries", tries, 2);
    idle(12);

    // Round-robin run on all four ways.
    clear_stats();
    for (int i = 0; i < RUN_LEN; i++)
      for (int w = 0; w < WAYS; w++) send(w, rand_rec($urandom()), tries);
    idle(12);
    check_int("rr_run_end_total", re_cnt[0] + re_cnt[1] + re_cnt[2] + re_cnt[3], 4);

    // Way 2 with TREE_FULL[2] toggling every cycle.
    clear_stats();
    TREE_FULL = 4'b0100;
    for (int i = 0; i < 5; i++) send(2, rand_rec($urandom()), tries);
    for (int i = 0; i < 12; i++) begin
      TREE_FULL[2] = ~TREE_FULL[2];
      check_cycle();
    end
    TREE_FULL = '0;
    idle(4);
    check_int("toggle_delivered", en_cnt[2], 5);
    check_int("toggle_no_sentinel", re_cnt[2], 0);
    for (int i = 0; i < 11; i++) send(2, rand_rec($urandom()), tries);
    idle(4);
    check_int("toggle_run_end", re_cnt[2], 1);
    check_int("toggle_total", en_cnt[2], RUN_LEN + 1);

    // Reset mid-run on way 1 discards the partial run.
    for (int i = 0; i < 10; i++) send(1, rand_rec($urandom()), tries);
    idle(3);
    do_reset();
    clear_stats();
    @(posedge CLK); #1;
    for (int i = 0; i < RUN_LEN; i++) send(1, rand_rec($urandom()), tries);
    idle(4);
    check_int("post_reset_run_end", re_cnt[1], 1);
    check_int("post_reset_total", en_cnt[1], RUN_LEN + 1);

    // Random traffic with random backpressure.
    for (int i = 0; i < 1500; i++) begin
      IN_VLD  = ($urandom_range(3) != 0);
      IN_WAY  = W_LOG'($urandom_range(WAYS - 1));
      IN_DATA = rand_rec($urandom());
      for (int w = 0; w < WAYS; w++) TREE_FULL[w] = ($urandom_range(9) < 3);
      check_cycle();
    end
    TREE_FULL = '0;
    idle(40);
    check_zero_outputs("drained");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
